// File: rtl/block_map_buffer_if.sv
// rtl/block_map_buffer_if.sv - generator, scroll and cell read signals of the block map buffer
interface block_map_buffer_if #(
  parameter int COLS = 7
);
  logic            load_layer;
  logic [0:COLS-1] layer_map;
  logic [0:COLS-1] block_type;
  logic            map_ready;
  logic            scroll;
  logic [3:0]      rd_layer;
  logic [2:0]      rd_col;
  logic            rd_present;
  logic            rd_type;
  logic [3:0]      layer_count;
  logic            map_valid;
  logic            layer_request;
  logic            overflow;

  modport master (
    output load_layer, layer_map, block_type, map_ready, scroll, rd_layer, rd_col,
    input  rd_present, rd_type, layer_count, map_valid, layer_request, overflow
  );

  modport slave (
    input  load_layer, layer_map, block_type, map_ready, scroll, rd_layer, rd_col,
    output rd_present, rd_type, layer_count, map_valid, layer_request, overflow
  );
endinterface

// File: rtl/block_map_buffer.sv
// rtl/block_map_buffer.sv - layered playfield store with scroll, refill request and cell read port
module block_map_buffer #(
  parameter int COLS   = 7,
  parameter int LAYERS = 8
) (
  input logic              clk,
  input logic              rst,
  block_map_buffer_if.slave bus
);
  localparam int LW = $clog2(LAYERS);
  localparam int CW = $clog2(COLS);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY, S_REFILL} state_t;

  state_t          state;
  state_t          next_state;
  logic [0:COLS-1] pres_mem [LAYERS];
  logic [0:COLS-1] type_mem [LAYERS];
  logic [3:0]      count;
  logic            full;
  logic            shift_ok;
  logic            load_ok;
  logic            load_drop;
  logic [3:0]      wr_idx;
  logic            rd_hit;
  logic            rd_present_q;
  logic            rd_type_q;
  logic            map_valid_q;
  logic            request_q;
  logic            overflow_q;

  // Scrolls only count in S_READY; a scroll frees a slot, so a load alongside it is never dropped.
  assign full      = (count == 4'(LAYERS));
  assign shift_ok  = bus.scroll && (state == S_READY) && (count != 4'd0);
  assign load_ok   = bus.load_layer && (!full || shift_ok);
  assign load_drop = bus.load_layer && !load_ok;
  assign wr_idx    = shift_ok ? (count - 4'd1) : count;
  assign rd_hit    = (int'(bus.rd_layer) < LAYERS) && (int'(bus.rd_col) < COLS);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state decode; the load paired with the entering scroll does not end the refill wait.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (load_ok)       next_state = S_FILL;
      S_FILL:   if (bus.map_ready) next_state = S_READY;
      S_READY:  if (shift_ok)      next_state = S_REFILL;
      S_REFILL: if (load_ok)       next_state = S_READY;
      default:                     next_state = S_IDLE;
    endcase
  end

  // Layer storage: shift down first, then the incoming layer lands on top of the stack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAYERS; i++) begin
        pres_mem[i] <= '0;
        type_mem[i] <= '0;
      end
    end else begin
      if (shift_ok) begin
        for (int i = 0; i < LAYERS - 1; i++) begin
          pres_mem[i] <= pres_mem[i+1];
          type_mem[i] <= type_mem[i+1];
        end
        pres_mem[LAYERS-1] <= '0;
        type_mem[LAYERS-1] <= '0;
      end
      if (load_ok) begin
        pres_mem[wr_idx[LW-1:0]] <= bus.layer_map;
        type_mem[wr_idx[LW-1:0]] <= bus.block_type;
      end
    end
  end

  // Occupancy count, sticky overflow, refill request and map-valid flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= 4'd0;
      overflow_q  <= 1'b0;
      request_q   <= 1'b0;
      map_valid_q <= 1'b0;
    end else begin
      case ({load_ok, shift_ok})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: count <= count;
      endcase
      if (load_drop) overflow_q <= 1'b1;
      request_q   <= shift_ok;
      map_valid_q <= (next_state == S_READY) || (next_state == S_REFILL);
    end
  end

  // Registered cell read; sees pre-write contents, out-of-range addresses read as empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_present_q <= 1'b0;
      rd_type_q    <= 1'b0;
    end else if (rd_hit) begin
      rd_present_q <= pres_mem[bus.rd_layer[LW-1:0]][bus.rd_col[CW-1:0]];
      rd_type_q    <= type_mem[bus.rd_layer[LW-1:0]][bus.rd_col[CW-1:0]];
    end else begin
      rd_present_q <= 1'b0;
      rd_type_q    <= 1'b0;
    end
  end

  assign bus.rd_present    = rd_present_q;
  assign bus.rd_type       = rd_type_q;
  assign bus.layer_count   = count;
  assign bus.map_valid     = map_valid_q;
  assign bus.layer_request = request_q;
  assign bus.overflow      = overflow_q;
endmodule

// File: tb/tb_block_map_buffer.sv
// tb/tb_block_map_buffer.sv - randomized and directed self-checking bench for block_map_buffer
module tb_block_map_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   started = 1'b0;

  block_map_buffer_if #(.COLS(7)) bus ();

  block_map_buffer #(.COLS(7), .LAYERS(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: the stack is a queue of layers, bottom first.
  logic [0:6] pq[$];
  logic [0:6] tq[$];
  bit m_loaded, m_valid, m_waiting, m_ovf, m_req, m_rdp, m_rdt;

  function automatic bit mcell(int l, int c, bit t);
    if (l >= 8 || c >= 7 || l >= pq.size()) return 1'b0;
    return t ? tq[l][c] : pq[l][c];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pq.delete(); tq.delete();
      m_loaded = 0; m_valid = 0; m_waiting = 0; m_ovf = 0; m_req = 0; m_rdp = 0; m_rdt = 0;
    end else begin
      bit do_shift, do_load;
      m_rdp = mcell(int'(bus.rd_layer), int'(bus.rd_col), 1'b0);
      m_rdt = mcell(int'(bus.rd_layer), int'(bus.rd_col), 1'b1);
      do_shift = bus.scroll && m_valid && !m_waiting && pq.size() > 0;
      do_load  = bus.load_layer && (pq.size() < 8 || do_shift);
      if (do_shift) begin
        void'(pq.pop_front());
        void'(tq.pop_front());
      end
      if (do_load) begin
        pq.push_back(bus.layer_map);
        tq.push_back(bus.block_type);
      end else if (bus.load_layer) begin
        m_ovf = 1;
      end
      m_req = do_shift;
      if (do_shift) m_waiting = 1;
      else if (m_waiting && do_load) m_waiting = 0;
      if (!m_valid && m_loaded && bus.map_ready) m_valid = 1;
      if (do_load) m_loaded = 1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the reference each cycle.
  always @(negedge clk) begin
    if (started && !rst) begin
      chk("cmp_rd_present", int'(bus.rd_present), int'(m_rdp));
      chk("cmp_rd_type", int'(bus.rd_type), int'(m_rdt));
      chk("cmp_layer_count", int'(bus.layer_count), pq.size());
      chk("cmp_map_valid", int'(bus.map_valid), int'(m_valid));
      chk("cmp_layer_request", int'(bus.layer_request), int'(m_req));
      chk("cmp_overflow", int'(bus.overflow), int'(m_ovf));
    end
  end

  task automatic cyc(input bit ld, input logic [0:6] lm, input logic [0:6] bt,
                     input bit mr, input bit sc, input int rl, input int rc);
    bus.load_layer = ld;
    bus.layer_map  = lm;
    bus.block_type = bt;
    bus.map_ready  = mr;
    bus.scroll     = sc;
    bus.rd_layer   = 4'(rl);
    bus.rd_col     = 3'(rc);
    @(negedge clk);
  endtask

  task automatic idle(input int rl, input int rc);
    cyc(0, 7'b0, 7'b0, 0, 0, rl, rc);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_present"}, int'(bus.rd_present), 0);
    chk({tag, "_rd_type"}, int'(bus.rd_type), 0);
    chk({tag, "_layer_count"}, int'(bus.layer_count), 0);
    chk({tag, "_map_valid"}, int'(bus.map_valid), 0);
    chk({tag, "_layer_request"}, int'(bus.layer_request), 0);
    chk({tag, "_overflow"}, int'(bus.overflow), 0);
  endtask

  initial begin
    logic [0:6] last_pm, last_tm, keep_pm, keep_tm, rp, rt;
    bus.load_layer = 0; bus.layer_map = '0; bus.block_type = '0;
    bus.map_ready = 0; bus.scroll = 0; bus.rd_layer = '0; bus.rd_col = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst = 0;
    started = 1;

    // Generator sequence.
    cyc(1, 7'b0001000, 7'b0000000, 0, 0, 0, 0);
    cyc(1, 7'b1010101, 7'b1000101, 1, 0, 0, 0);
    chk("valid_after_l2", int'(bus.map_valid), 1);
    cyc(1, 7'b0101010, 7'b0001010, 0, 0, 0, 0);
    cyc(1, 7'b1010101, 7'b0010101, 1, 0, 0, 0);
    chk("count_4", int'(bus.layer_count), 4);
    chk("model_count_4", pq.size(), 4);
    idle(0, 3); chk("rd03_p", int'(bus.rd_present), 1); chk("rd03_t", int'(bus.rd_type), 0);
    idle(1, 0); chk("rd10_p", int'(bus.rd_present), 1); chk("rd10_t", int'(bus.rd_type), 1);
    idle(2, 1); chk("rd21_p", int'(bus.rd_present), 1); chk("rd21_t", int'(bus.rd_type), 0);
    idle(0, 0); chk("rd00_p", int'(bus.rd_present), 0); chk("rd00_t", int'(bus.rd_type), 0);
    idle(3, 6); chk("rd36_p", int'(bus.rd_present), 1); chk("rd36_t", int'(bus.rd_type), 1);

    // Scroll, ignored second scroll, refill load.
    cyc(0, 7'b0, 7'b0, 0, 1, 0, 0);
    chk("scroll_count", int'(bus.layer_count), 3);
    chk("scroll_req", int'(bus.layer_request), 1);
    cyc(0, 7'b0, 7'b0, 0, 1, 0, 0);
    chk("scroll_req_once", int'(bus.layer_request), 0);
    chk("scroll2_count", int'(bus.layer_count), 3);
    chk("rd00_after_p", int'(bus.rd_present), 1); chk("rd00_after_t", int'(bus.rd_type), 1);
    idle(3, 6); chk("slot3_clear", int'(bus.rd_present), 0);
    cyc(1, 7'b1100110, 7'b0100010, 0, 0, 0, 0);
    chk("refill_count", int'(bus.layer_count), 4);
    cyc(0, 7'b0, 7'b0, 0, 1, 0, 0);
    chk("ready_again_req", int'(bus.layer_request), 1);
    cyc(1, 7'b0011001, 7'b0001001, 0, 0, 0, 0);

    // Fill to 8, then overflow.
    last_pm = '0; last_tm = '0;
    for (int k = 0; k < 10 && pq.size() < 8; k++) begin
      last_pm = 7'($urandom); last_tm = 7'($urandom);
      cyc(1, last_pm, last_tm, 0, 0, 0, 0);
    end
    cyc(1, 7'b1111111, 7'b1111111, 0, 0, 0, 0);
    chk("ovf_set", int'(bus.overflow), 1);
    chk("ovf_count", int'(bus.layer_count), 8);
    chk("model_ovf", int'(m_ovf), 1);
    for (int c = 0; c < 7; c++) begin
      idle(7, c);
      chk("slot7_p", int'(bus.rd_present), int'(last_pm[c]));
      chk("slot7_t", int'(bus.rd_type), int'(last_tm[c]));
    end
    cyc(0, 7'b0, 7'b0, 0, 1, 0, 0);
    cyc(1, 7'b0000001, 7'b0, 0, 0, 0, 0);
    chk("ovf_sticky", int'(bus.overflow), 1);

    // Asynchronous reset just after an accepted scroll.
    cyc(0, 7'b0, 7'b0, 0, 1, 0, 0);
    chk("pre_rst_req", int'(bus.layer_request), 1);
    #1 rst = 1;
    #1 chk_all_zero("async_rst");
    @(negedge clk);
    rst = 0;
    idle(0, 0); chk("post_rst_req", int'(bus.layer_request), 0);
    cyc(1, 7'b0110011, 7'b0010001, 0, 0, 0, 0);
    idle(0, 1); chk("post_rst_rd01_p", int'(bus.rd_present), 1); chk("post_rst_rd01_t", int'(bus.rd_type), 0);
    idle(0, 6); chk("post_rst_rd06_p", int'(bus.rd_present), 1); chk("post_rst_rd06_t", int'(bus.rd_type), 1);

    // Simultaneous load and scroll at count 5.
    keep_pm = 7'b1001110; keep_tm = 7'b0001100;
    cyc(1, keep_pm, keep_tm, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(1, 7'($urandom), 7'($urandom), 0, 0, 0, 0);
    chk("five_count", int'(bus.layer_count), 5);
    cyc(1, 7'b1111111, 7'b0000000, 0, 1, 0, 0);
    chk("sim_count", int'(bus.layer_count), 5);
    chk("sim_req", int'(bus.layer_request), 1);
    idle(4, 0); chk("sim_req_once", int'(bus.layer_request), 0);
    chk("sim_slot4_p", int'(bus.rd_present), 1); chk("sim_slot4_t", int'(bus.rd_type), 0);
    for (int c = 0; c < 7; c++) begin
      idle(0, c);
      chk("sim_slot0_p", int'(bus.rd_present), int'(keep_pm[c]));
      chk("sim_slot0_t", int'(bus.rd_type), int'(keep_tm[c]));
    end

    // Out-of-range reads.
    idle(9, 7); chk("oor97_p", int'(bus.rd_present), 0); chk("oor97_t", int'(bus.rd_type), 0);
    idle(0, 7); chk("oor07_p", int'(bus.rd_present), 0);
    idle(9, 0); chk("oor90_p", int'(bus.rd_present), 0);

    // Randomized traffic against the reference, with one mid-run reset.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        rst = 1;
        @(negedge clk);
        rst = 0;
      end
      rp = 7'($urandom); rt = 7'($urandom);
      cyc(($urandom_range(0, 9) < 4), rp, rt, ($urandom_range(0, 9) < 2),
          ($urandom_range(0, 9) < 3), int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
    end
    idle(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
